// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single-port data memory.
// Grants are combinational, so the memory access happens in the grant cycle.
// Read data is registered and returned one cycle later.
// An optional bounded lock keeps the grant with one master for multi-beat sequences.
module dmem_arbiter #(
   parameter int unsigned LOCK_MAX = 8,
   parameter int unsigned AW       = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   input  logic          m0_we,
   input  logic          m0_byte,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [31:0]   m0_rdata,
   input  logic          m1_req,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic          m1_we,
   input  logic          m1_byte,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [31:0]   m1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [1:0]    mem_memwrite,
   input  logic [31:0]   mem_rdata
);

   localparam int unsigned CW      = $clog2(LOCK_MAX + 1);
   localparam bit          LOCK_EN = (LOCK_MAX > 1);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rvalid0_q, rvalid0_d;
   logic          rvalid1_q, rvalid1_d;
   logic [31:0]   rdata0_q, rdata0_d;
   logic [31:0]   rdata1_q, rdata1_d;

   // State, round-robin history, lock counter and read-response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   // Next state: pick the IDLE winner, enter/hold/release the lock
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (m0_gnt) begin
               last_d = 1'b0;
               if (m0_lock && LOCK_EN) begin
                  state_d = LOCK0;
                  cnt_d   = CW'(1);
               end
            end else if (m1_gnt) begin
               last_d = 1'b1;
               if (m1_lock && LOCK_EN) begin
                  state_d = LOCK1;
                  cnt_d   = CW'(1);
               end
            end
         end
         LOCK0: begin
            if (!m0_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               last_d = 1'b0;
               cnt_d  = cnt_q + CW'(1);
               if (!m0_lock || (cnt_q >= CW'(LOCK_MAX - 1))) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         LOCK1: begin
            if (!m1_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               last_d = 1'b1;
               cnt_d  = cnt_q + CW'(1);
               if (!m1_lock || (cnt_q >= CW'(LOCK_MAX - 1))) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: grants, memory mux and read-response capture
   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_req && (!m1_req || last_q)) m0_gnt = 1'b1;
            else if (m1_req)                   m1_gnt = 1'b1;
         end
         LOCK0:   m0_gnt = m0_req;
         LOCK1:   m1_gnt = m1_req;
         default: ;
      endcase

      mem_addr     = '0;
      mem_wdata    = '0;
      mem_memwrite = 2'b00;
      if (m0_gnt) begin
         mem_addr     = m0_addr;
         mem_wdata    = m0_wdata;
         mem_memwrite = {m0_byte, m0_we};
      end else if (m1_gnt) begin
         mem_addr     = m1_addr;
         mem_wdata    = m1_wdata;
         mem_memwrite = {m1_byte, m1_we};
      end

      rvalid0_d = m0_gnt && !m0_we;
      rvalid1_d = m1_gnt && !m1_we;
      rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
      rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;

      m0_rvalid = rvalid0_q;
      m1_rvalid = rvalid1_q;
      m0_rdata  = rdata0_q;
      m1_rdata  = rdata1_q;
   end

endmodule
